// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU controller slice:
// default widths, ALU opcodes and the controller FSM encoding.
package alu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CMD_W  = 3;

    localparam logic [DEF_CMD_W-1:0] OP_ADD = 3'b000;
    localparam logic [DEF_CMD_W-1:0] OP_SUB = 3'b001;
    localparam logic [DEF_CMD_W-1:0] OP_AND = 3'b010;
    localparam logic [DEF_CMD_W-1:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Any opcode with the top bit set is reserved.
    function automatic logic cmd_illegal(input logic [DEF_CMD_W-1:0] cmd);
        return cmd[DEF_CMD_W-1];
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request and response channels between client engines and the
// shared-ALU controller.
interface alu_share_ctrl_if #(
    parameter int DATA_W = alu_pkg::DEF_DATA_W,
    parameter int CMD_W  = alu_pkg::DEF_CMD_W,
    parameter int N_REQ  = 2,
    parameter int ID_W   = $clog2(N_REQ)
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ*CMD_W-1:0]  req_cmd;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_y;
    logic              rsp_z;
    logic              rsp_c;
    logic              rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_cmd, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y,
        input  rsp_z, rsp_c, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cmd, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y,
        output rsp_z, rsp_c, rsp_err
    );

endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU shared by the requesters; lives outside
// the controller and is wired to its alu_* ports.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CMD_W  = DEF_CMD_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [CMD_W-1:0]  cmd,
    output logic [DATA_W-1:0] y,
    output logic              z,
    output logic              c
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum = '0;
        y   = '0;
        c   = 1'b0;
        case (cmd)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[DATA_W-1:0];
                c   = sum[DATA_W];
            end
            // Top bit of the wide difference is the borrow.
            OP_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                y   = sum[DATA_W-1:0];
                c   = sum[DATA_W];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

    assign z = ~|y;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last-grant pointer
// and the first active request wins.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    function automatic int wrap(input int p, input int i);
        return (p + i) % N_REQ;
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (en && !any && req[wrap(int'(ptr), i)]) begin
                grant[wrap(int'(ptr), i)] = 1'b1;
                idx = ID_W'(wrap(int'(ptr), i));
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU among N_REQ requesters: accept one op,
// drive the ALU from registered operands, return the captured result.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CMD_W  = DEF_CMD_W,
    parameter int N_REQ  = 2,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_ctrl_if.slave   bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CMD_W-1:0]  alu_cmd,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_z,
    input  logic              alu_c,
    output logic              busy
);

    state_t state_q, state_d;

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] y_q;
    logic              z_q;
    logic              c_q;
    logic              err_q;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   win;
    logic              accept;
    logic              arb_en;

    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic [CMD_W-1:0]  cmd_sel;

    // Gating with rst_n keeps req_ready low throughout reset.
    assign arb_en = (state_q == ST_IDLE) && rst_n;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .en    (arb_en),
        .grant (grant),
        .idx   (win),
        .any   (accept)
    );

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cmd_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                a_sel   = bus.req_a[i*DATA_W +: DATA_W];
                b_sel   = bus.req_b[i*DATA_W +: DATA_W];
                cmd_sel = bus.req_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_cmd <= '0;
        end else if (accept) begin
            ptr_q   <= win;
            id_q    <= win;
            alu_a   <= a_sel;
            alu_b   <= b_sel;
            alu_cmd <= cmd_sel;
        end
    end

    // Reserved opcodes report an error with all result fields cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            err_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            if (cmd_illegal(alu_cmd)) begin
                y_q   <= '0;
                z_q   <= 1'b0;
                c_q   <= 1'b0;
                err_q <= 1'b1;
            end else begin
                y_q   <= alu_y;
                z_q   <= alu_z;
                c_q   <= alu_c;
                err_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_y     = y_q;
    assign bus.rsp_z     = z_q;
    assign bus.rsp_c     = c_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with the ALU wired in: latency,
// flags, round-robin order, backpressure, illegal ops and mid-op reset.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int DW = 8;
    localparam int CW = 3;
    localparam int NR = 2;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst_n;

    logic [DW-1:0] alu_a, alu_b, alu_y;
    logic [CW-1:0] alu_cmd;
    logic          alu_z, alu_c, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_ctrl_if #(.DATA_W(DW), .CMD_W(CW), .N_REQ(NR), .ID_W(IW)) bus ();

    alu_share_ctrl #(
        .DATA_W (DW),
        .CMD_W  (CW),
        .N_REQ  (NR),
        .ID_W   (IW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_cmd (alu_cmd),
        .alu_y   (alu_y),
        .alu_z   (alu_z),
        .alu_c   (alu_c),
        .busy    (busy)
    );

    alu #(.DATA_W(DW), .CMD_W(CW)) u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .cmd (alu_cmd),
        .y   (alu_y),
        .z   (alu_z),
        .c   (alu_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setop(input int r, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [CW-1:0] cmd);
        bus.req_a[r*DW +: DW]   = a;
        bus.req_b[r*DW +: DW]   = b;
        bus.req_cmd[r*CW +: CW] = cmd;
    endtask

    task automatic chk_rsp(input string t, input int id, input int y,
                           input int z, input int c, input int err);
        chk({t, "_valid"}, 32'(bus.rsp_valid), 1);
        chk({t, "_id"}, 32'(bus.rsp_id), 32'(id));
        chk({t, "_y"}, 32'(bus.rsp_y), 32'(y));
        chk({t, "_z"}, 32'(bus.rsp_z), 32'(z));
        chk({t, "_c"}, 32'(bus.rsp_c), 32'(c));
        chk({t, "_err"}, 32'(bus.rsp_err), 32'(err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cmd   = '0;
        bus.rsp_ready = 1'b1;

        #12;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_id", 32'(bus.rsp_id), 0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single op, latency 2
        setop(0, 8'hA3, 8'h65, OP_ADD);
        bus.req_valid = 2'b01;
        #1 chk("t1_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1 chk("t1_busy", 32'(busy), 1);
        chk("t1_exec_valid", 32'(bus.rsp_valid), 0);
        chk("t1_alu_a", 32'(alu_a), 32'hA3);
        chk("t1_alu_b", 32'(alu_b), 32'h65);
        @(negedge clk);
        #1 chk_rsp("t1", 0, 32'h08, 0, 1, 0);
        @(negedge clk);
        #1 chk("t1_idle_valid", 32'(bus.rsp_valid), 0);

        // zero flag from requester 1
        setop(1, 8'hF0, 8'h0E, OP_AND);
        bus.req_valid = 2'b10;
        #1 chk("t2_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1 chk_rsp("t2", 1, 32'h00, 1, 0, 0);
        @(negedge clk);

        // contention
        setop(0, 8'h7F, 8'h01, OP_ADD);
        setop(1, 8'h01, 8'h02, OP_SUB);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            #1 chk($sformatf("t3_grant%0d", k), 32'(bus.req_ready),
                   32'(1 << g));
            @(negedge clk);
            #1 chk($sformatf("t3_exec_ready%0d", k), 32'(bus.req_ready), 0);
            @(negedge clk);
            #1 chk_rsp($sformatf("t3_%0d", k), g,
                       (g == 0) ? 32'h80 : 32'hFF, 0, g, 0);
            @(negedge clk);
        end

        // backpressure
        setop(0, 8'h5A, 8'hA5, OP_OR);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b0;
        #1 chk("t4_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("t4_hold_valid%0d", i), 32'(bus.rsp_valid), 1);
            chk($sformatf("t4_hold_y%0d", i), 32'(bus.rsp_y), 32'hFF);
            chk($sformatf("t4_hold_ready%0d", i), 32'(bus.req_ready), 0);
            chk($sformatf("t4_hold_busy%0d", i), 32'(busy), 1);
            @(negedge clk);
        end
        #1 chk_rsp("t4", 0, 32'hFF, 0, 0, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1 chk("t4_next_ready", 32'(bus.req_ready), 32'h2);
        chk("t4_next_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1 chk_rsp("t4b", 1, 32'hFF, 0, 1, 0);
        @(negedge clk);

        // illegal command
        setop(0, 8'h12, 8'h34, 3'b100);
        bus.req_valid = 2'b01;
        #1 chk("t5_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1 chk("t5_exec_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        #1 chk_rsp("t5", 0, 32'h00, 0, 0, 1);
        @(negedge clk);

        // reset in EXEC
        setop(1, 8'h33, 8'h44, OP_ADD);
        bus.req_valid = 2'b10;
        #1 chk("t6_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        #1 chk("t6_exec_busy", 32'(busy), 1);
        chk("t6_exec_alu_a", 32'(alu_a), 32'h33);
        rst_n = 1'b0;
        #1 chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_alu_a", 32'(alu_a), 0);
        chk("t6_rst_alu_b", 32'(alu_b), 0);
        chk("t6_rst_err", 32'(bus.rsp_err), 0);
        chk("t6_rst_id", 32'(bus.rsp_id), 0);
        chk("t6_rst_valid", 32'(bus.rsp_valid), 0);
        chk("t6_rst_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        #1 chk("t6_rst_hold_valid", 32'(bus.rsp_valid), 0);
        rst_n = 1'b1;
        #1 chk("t6_rel_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1 chk_rsp("t6", 1, 32'h77, 0, 0, 0);
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1 chk("t6_tie_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1 chk_rsp("t6b", 0, 32'h00, 0, 0, 1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
